// File: rtl/sht21_meas_sched.sv
`default_nettype none
// ============================================================================
// Module  : sht21_meas_sched
// Brief   : Sequences SHT21 temperature/humidity hold-master reads on the IIC
//           controller, validates status bits, latches results, and times out
//           stalled transactions.
// Revision: 1.0 - initial release
// ============================================================================
module sht21_meas_sched #(
   parameter logic [9:0]  SCL_DIV     = 10'd500,
   parameter logic [7:0]  WR_ADDR     = 8'h80,
   parameter logic [7:0]  RD_ADDR     = 8'h81,
   parameter logic [7:0]  CMD_T       = 8'hE3,
   parameter logic [7:0]  CMD_RH      = 8'hE5,
   parameter int unsigned GAP_CYC     = 16,
   parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000,
   parameter logic [23:0] PERIOD_CYC  = 24'd50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        trig,
   output logic [9:0]  sclDiv,
   output logic [7:0]  dev_wradd,
   output logic [7:0]  dev_rdadd,
   output logic [7:0]  dev_sdcmd,
   output logic        iic_en,
   input  logic        iic_ack,
   input  logic [7:0]  iic_rdms,
   input  logic [7:0]  iic_rdls,
   output logic [15:0] temp_raw,
   output logic [15:0] rh_raw,
   output logic        temp_vld,
   output logic        rh_vld,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned    GAP_W    = $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [23:0]    TMO_LAST = TIMEOUT_CYC - 24'd1;
   localparam logic [23:0]    PER_LAST = PERIOD_CYC - 24'd1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_T_REQ = 3'd1,
      S_T_GAP = 3'd2,
      S_H_REQ = 3'd3,
      S_H_GAP = 3'd4,
      S_WAIT  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              ack_s_q, ack_s_d;
   logic              ack_d_q, ack_d_d;
   logic [23:0]       tmo_q, tmo_d;
   logic [23:0]       per_q, per_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [7:0]        sdcmd_q, sdcmd_d;
   logic [15:0]       temp_raw_q, temp_raw_d;
   logic [15:0]       rh_raw_q, rh_raw_d;
   logic              temp_vld_q, temp_vld_d;
   logic              rh_vld_q, rh_vld_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              ack_rise;
   logic              is_h;
   logic              status_ok;
   logic [15:0]       raw_word;
   logic              unused_rdls0;

   assign ack_rise     = ack_s_q & ~ack_d_q;
   assign is_h         = (state_q == S_H_REQ);
   assign status_ok    = (iic_rdls[1] == is_h);
   assign raw_word     = {iic_rdms, iic_rdls[7:2], 2'b00};
   assign unused_rdls0 = iic_rdls[0];

   always_comb begin
      state_d    = state_q;
      ack_s_d    = iic_ack;
      ack_d_d    = ack_s_q;
      tmo_d      = (tmo_q == '1) ? tmo_q : tmo_q + 24'd1;
      per_d      = (per_q == '1) ? per_q : per_q + 24'd1;
      gap_d      = (gap_q == '1) ? gap_q : gap_q + 1'b1;
      sdcmd_d    = sdcmd_q;
      temp_raw_d = temp_raw_q;
      rh_raw_d   = rh_raw_q;
      temp_vld_d = 1'b0;
      rh_vld_d   = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (trig || run) begin
               state_d = S_T_REQ;
               sdcmd_d = CMD_T;
               tmo_d   = '0;
               per_d   = '0;
            end
         end
         S_T_REQ, S_H_REQ: begin
            // An acknowledge edge takes priority over a coincident timeout.
            if (ack_rise) begin
               if (status_ok) begin
                  if (is_h) begin
                     rh_raw_d = raw_word;
                     rh_vld_d = 1'b1;
                  end else begin
                     temp_raw_d = raw_word;
                     temp_vld_d = 1'b1;
                  end
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'b10;
               end
               state_d = is_h ? S_H_GAP : S_T_GAP;
               gap_d   = '0;
            end else if (tmo_q >= TMO_LAST) begin
               err_d      = 1'b1;
               err_code_d = 2'b01;
               state_d    = is_h ? S_H_GAP : S_T_GAP;
               gap_d      = '0;
            end
         end
         S_T_GAP: begin
            if (gap_q >= GAP_LAST) begin
               state_d = S_H_REQ;
               sdcmd_d = CMD_RH;
               tmo_d   = '0;
            end
         end
         S_H_GAP: begin
            if (gap_q >= GAP_LAST) begin
               state_d = run ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (per_q >= PER_LAST) begin
               state_d = S_T_REQ;
               sdcmd_d = CMD_T;
               tmo_d   = '0;
               per_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ack_s_q    <= 1'b0;
         ack_d_q    <= 1'b0;
         tmo_q      <= '0;
         per_q      <= '0;
         gap_q      <= '0;
         sdcmd_q    <= CMD_T;
         temp_raw_q <= '0;
         rh_raw_q   <= '0;
         temp_vld_q <= 1'b0;
         rh_vld_q   <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         ack_s_q    <= ack_s_d;
         ack_d_q    <= ack_d_d;
         tmo_q      <= tmo_d;
         per_q      <= per_d;
         gap_q      <= gap_d;
         sdcmd_q    <= sdcmd_d;
         temp_raw_q <= temp_raw_d;
         rh_raw_q   <= rh_raw_d;
         temp_vld_q <= temp_vld_d;
         rh_vld_q   <= rh_vld_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   // Decoded straight from state so an asynchronous reset drops them at once.
   assign iic_en    = (state_q == S_T_REQ) || (state_q == S_H_REQ);
   assign busy      = (state_q != S_IDLE) && (state_q != S_WAIT);
   assign sclDiv    = SCL_DIV;
   assign dev_wradd = WR_ADDR;
   assign dev_rdadd = RD_ADDR;
   assign dev_sdcmd = sdcmd_q;
   assign temp_raw  = temp_raw_q;
   assign rh_raw    = rh_raw_q;
   assign temp_vld  = temp_vld_q;
   assign rh_vld    = rh_vld_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_sht21_meas_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sht21_meas_sched
// Brief   : Scoreboard bench for sht21_meas_sched with a behavioural IIC
//           controller that acknowledges 50 cycles after iic_en rises.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sht21_meas_sched;

   localparam int GAP = 4;
   localparam int TMO = 200;
   localparam int PER = 1000;

   logic        clk = 1'b0;
   logic        rst_n, run, trig;
   logic [9:0]  sclDiv;
   logic [7:0]  dev_wradd, dev_rdadd, dev_sdcmd;
   logic        iic_en, iic_ack;
   logic [7:0]  iic_rdms, iic_rdls;
   logic [15:0] temp_raw, rh_raw;
   logic        temp_vld, rh_vld, err, busy;
   logic [1:0]  err_code;

   sht21_meas_sched #(
      .GAP_CYC    (GAP),
      .TIMEOUT_CYC(24'd200),
      .PERIOD_CYC (24'd1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .trig(trig),
      .sclDiv(sclDiv), .dev_wradd(dev_wradd), .dev_rdadd(dev_rdadd),
      .dev_sdcmd(dev_sdcmd), .iic_en(iic_en), .iic_ack(iic_ack),
      .iic_rdms(iic_rdms), .iic_rdls(iic_rdls), .temp_raw(temp_raw),
      .rh_raw(rh_raw), .temp_vld(temp_vld), .rh_vld(rh_vld), .err(err),
      .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 temp, 1 rh, 2 err
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   t_rise[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_rise = 0;
   int   last_fall = 0;

   bit       t_noack = 0;
   int       hold_len = 1;
   logic [7:0] t_ms = 8'h66, t_ls = 8'h7C, h_ms = 8'h5A, h_ls = 8'hD2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [15:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input logic [15:0] val);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d value 0x%0h expected nothing", kind, val);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.val !== val) begin
            errors++;
            $display("FAIL scoreboard: got kind %0d value 0x%0h expected kind %0d value 0x%0h",
                     kind, val, e.kind, e.val);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural IIC controller.
   initial begin
      int m_cnt, m_hold;
      bit m_act, m_h, m_en_p;
      iic_ack = 0; iic_rdms = 0; iic_rdls = 0;
      m_cnt = 0; m_hold = 0; m_act = 0; m_h = 0; m_en_p = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            iic_ack = 0; m_act = 0; m_hold = 0; m_en_p = 0;
         end else begin
            if (m_hold > 0) begin
               m_hold--;
               if (m_hold == 0) iic_ack = 0;
            end
            if (iic_en && !m_en_p) begin
               m_act = 1; m_cnt = 0; m_h = (dev_sdcmd == 8'hE5);
            end
            if (!iic_en) m_act = 0;
            m_en_p = iic_en;
            if (m_act) begin
               m_cnt++;
               if (m_cnt == 50) begin
                  m_act = 0;
                  if (!(t_noack && !m_h)) begin
                     iic_rdms = m_h ? h_ms : t_ms;
                     iic_rdls = m_h ? h_ls : t_ls;
                     iic_ack  = 1;
                     m_hold   = hold_len;
                  end
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every output event and tracks iic_en edges.
   initial begin
      bit en_p, expect_h;
      en_p = 0; expect_h = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            en_p = 0; expect_h = 0;
            continue;
         end
         if (temp_vld && rh_vld) chk("vld_exclusive", 32'(temp_vld & rh_vld), 0);
         if (temp_vld) sb_pop(0, temp_raw);
         if (rh_vld)   sb_pop(1, rh_raw);
         if (err) begin
            sb_pop(2, {14'd0, err_code});
            if (err_code == 2'b01) chk("timeout_latency", 32'(cyc - last_rise), TMO);
         end
         if (iic_en && !en_p) begin
            chk("sdcmd_at_req", {24'd0, dev_sdcmd}, expect_h ? 32'hE5 : 32'hE3);
            if (expect_h) chk("gap_len", 32'(cyc - last_fall), GAP);
            else t_rise.push_back(cyc);
            last_rise = cyc;
            expect_h  = !expect_h;
         end
         if (!iic_en && en_p) last_fall = cyc;
         en_p = iic_en;
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || iic_en) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_within_budget", 32'(n < budget), 1);
   endtask

   task automatic pulse_trig();
      @(negedge clk); trig = 1;
      @(negedge clk); trig = 0;
   endtask

   initial begin
      int c0, n;
      rst_n = 0; run = 0; trig = 0;
      repeat (3) @(negedge clk);
      // Reset values
      chk("rst_iic_en", iic_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sdcmd", dev_sdcmd, 8'hE3);
      chk("rst_temp_raw", temp_raw, 0);
      chk("rst_rh_raw", rh_raw, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_pulses", {temp_vld, rh_vld, err}, 0);
      chk("scl_div", sclDiv, 10'd500);
      chk("addr_bytes", {dev_wradd, dev_rdadd}, 16'h8081);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // Basic one-shot pair
      expect_ev(0, 16'h667C);
      expect_ev(1, 16'h5AD0);
      trig = 1;
      @(posedge clk); #1;
      trig = 0;
      chk("trig_to_en", iic_en, 1);
      chk("trig_to_busy", busy, 1);
      wait_idle(500);
      chk("basic_sb_empty", sb.size(), 0);
      chk("basic_temp_raw", temp_raw, 16'h667C);
      chk("basic_rh_raw", rh_raw, 16'h5AD0);
      chk("basic_busy_low", busy, 0);

      // T transaction never acknowledged
      t_noack = 1;
      expect_ev(2, 16'h0001);
      expect_ev(1, 16'h5AD0);
      pulse_trig();
      wait_idle(1000);
      t_noack = 0;
      chk("tmo_sb_empty", sb.size(), 0);
      chk("tmo_err_code", err_code, 2'b01);

      // Status mismatch on T reply
      t_ls = 8'h7E;
      h_ms = 8'h3C; h_ls = 8'hA6;
      expect_ev(2, 16'h0002);
      expect_ev(1, 16'h3CA4);
      pulse_trig();
      wait_idle(500);
      t_ls = 8'h7C; h_ms = 8'h5A; h_ls = 8'hD2;
      chk("stat_sb_empty", sb.size(), 0);
      chk("stat_temp_raw_kept", temp_raw, 16'h667C);
      chk("stat_err_code", err_code, 2'b10);

      // trig while busy, long ack
      hold_len = 5;
      t_rise.delete();
      t_ms = 8'h12; t_ls = 8'h34;
      expect_ev(0, 16'h1234);
      expect_ev(1, 16'h5AD0);
      pulse_trig();
      repeat (20) @(negedge clk);
      pulse_trig();
      repeat (50) @(negedge clk);
      pulse_trig();
      wait_idle(500);
      repeat (200) @(negedge clk);
      hold_len = 1;
      t_ms = 8'h66; t_ls = 8'h7C;
      chk("busy_trig_one_pair", t_rise.size(), 1);
      chk("busy_sb_empty", sb.size(), 0);

      // Periodic run
      t_rise.delete();
      for (int i = 0; i < 4; i++) begin
         expect_ev(0, 16'h667C);
         expect_ev(1, 16'h5AD0);
      end
      @(negedge clk);
      c0 = cyc;
      run = 1;
      repeat (3500) @(negedge clk);
      run = 0;
      wait_idle(500);
      repeat (1200) @(negedge clk);
      chk("run_pair_count", t_rise.size(), 4);
      if (t_rise.size() == 4) begin
         chk("run_first_start", 32'(t_rise[0] - c0), 1);
         for (int i = 1; i < 4; i++) chk("run_period", 32'(t_rise[i] - t_rise[i-1]), PER);
      end
      chk("run_sb_empty", sb.size(), 0);
      chk("run_idle_busy", busy, 0);

      // Reset during H_REQ
      expect_ev(0, 16'h667C);
      pulse_trig();
      n = 0;
      while (!(iic_en && dev_sdcmd == 8'hE5) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_h_req", 32'(n < 300), 1);
      #2;
      rst_n = 0;
      #1;
      chk("arst_iic_en", iic_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_sdcmd", dev_sdcmd, 8'hE3);
      chk("arst_raw", {temp_raw, rh_raw}, 0);
      chk("arst_err_code", err_code, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      expect_ev(0, 16'h667C);
      expect_ev(1, 16'h5AD0);
      t_rise.delete();
      pulse_trig();
      wait_idle(500);
      chk("post_rst_pair", t_rise.size(), 1);
      chk("post_rst_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
